// File: rtl/start_fifo_srl_ctrl.sv
// -----------------------------------------------------------------------------
// start_fifo_srl_ctrl
//
// Control logic for a FIFO built on an external SRL shift register. Every
// push shifts the SRL by one position, which puts the newest entry at index 0.
// The oldest entry is therefore always at index cnt-1. The read address is
// taken from the registered occupancy count, and the SRL output is passed
// straight through to if_dout.
//
// Ports
//   clk, reset                 clock and synchronous active-high reset
//   if_write_ce, if_write      producer enable and request
//   if_din                     producer data
//   if_full_n                  registered, 1 = space available
//   if_read_ce, if_read        consumer enable and request
//   if_dout                    oldest entry, valid while if_empty_n = 1
//   if_empty_n                 registered, 1 = data available
//   srl_we, srl_addr, srl_din  drive the external SRL
//   srl_dout                   read data returned by the SRL
//
// Optional feature (macro START_FIFO_SRL_CTRL_OCCUPANCY_EN):
//   occupancy                  current entry count
//   max_occupancy              sticky high-watermark of the count, cleared by reset
// -----------------------------------------------------------------------------
module start_fifo_srl_ctrl #(
    parameter int DATA_WIDTH = 1,
    parameter int ADDR_WIDTH = 1,
    parameter int DEPTH      = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  if_write_ce,
    input  logic                  if_write,
    input  logic [DATA_WIDTH-1:0] if_din,
    output logic                  if_full_n,
    input  logic                  if_read_ce,
    input  logic                  if_read,
    output logic [DATA_WIDTH-1:0] if_dout,
    output logic                  if_empty_n,
    output logic                  srl_we,
    output logic [ADDR_WIDTH-1:0] srl_addr,
    output logic [DATA_WIDTH-1:0] srl_din,
    input  logic [DATA_WIDTH-1:0] srl_dout
`ifdef START_FIFO_SRL_CTRL_OCCUPANCY_EN
    ,
    output logic [ADDR_WIDTH:0]   occupancy,
    output logic [ADDR_WIDTH:0]   max_occupancy
`endif
);

    localparam int            CW      = ADDR_WIDTH + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] ONE_C   = CW'(1);

    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic          push;
    logic          pop;

    // Gate the requests with the registered flags. A write is refused whenever
    // the FIFO is full, even if a pop happens in the same cycle.
    assign push = if_write_ce & if_write & if_full_n;
    assign pop  = if_read_ce & if_read & if_empty_n;

    assign srl_we  = push;
    assign srl_din = if_din;
    assign if_dout = srl_dout;

    // When push and pop occur together, the shift moves the oldest entry up to
    // index cnt. Keeping the address at cnt-1 then exposes the next-oldest
    // entry, which is exactly the element that the pop leaves at the head.
    assign srl_addr = (cnt != '0) ? ADDR_WIDTH'(cnt - ONE_C) : '0;

    always_comb begin
        cnt_nxt = cnt;
        if (push && !pop) begin
            cnt_nxt = cnt + ONE_C;
        end else if (pop && !push) begin
            cnt_nxt = cnt - ONE_C;
        end
    end

    // The flags are computed from the next count, so they are registered
    // versions of the state the FIFO is about to enter.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt        <= '0;
            if_empty_n <= 1'b0;
            if_full_n  <= 1'b1;
        end else begin
            cnt        <= cnt_nxt;
            if_empty_n <= (cnt_nxt != '0);
            if_full_n  <= (cnt_nxt != DEPTH_C);
        end
    end

`ifdef START_FIFO_SRL_CTRL_OCCUPANCY_EN
    logic [CW-1:0] max_q;

    // The watermark follows the next count, so max_occupancy is never lower
    // than occupancy.
    always_ff @(posedge clk) begin
        if (reset) begin
            max_q <= '0;
        end else if (cnt_nxt > max_q) begin
            max_q <= cnt_nxt;
        end
    end

    assign occupancy     = cnt;
    assign max_occupancy = max_q;
`endif

endmodule

// File: tb/tb_start_fifo_srl_ctrl.sv
// -----------------------------------------------------------------------------
// Testbench for start_fifo_srl_ctrl (DEPTH=4, DATA_WIDTH=8, ADDR_WIDTH=2).
// An external SRL shift register is modelled here. The FIFO behaviour is
// predicted with a queue-based reference model.
// -----------------------------------------------------------------------------
module tb_start_fifo_srl_ctrl;

    localparam int DW    = 8;
    localparam int AW    = 2;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          if_write_ce, if_write, if_read_ce, if_read;
    logic [DW-1:0] if_din;
    logic          if_full_n, if_empty_n;
    logic [DW-1:0] if_dout;
    logic          srl_we;
    logic [AW-1:0] srl_addr;
    logic [DW-1:0] srl_din, srl_dout;
`ifdef START_FIFO_SRL_CTRL_OCCUPANCY_EN
    logic [AW:0]   occupancy, max_occupancy;
`endif

    always #5 clk = ~clk;

    start_fifo_srl_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .if_write_ce(if_write_ce), .if_write(if_write), .if_din(if_din),
        .if_full_n(if_full_n),
        .if_read_ce(if_read_ce), .if_read(if_read), .if_dout(if_dout),
        .if_empty_n(if_empty_n),
        .srl_we(srl_we), .srl_addr(srl_addr), .srl_din(srl_din), .srl_dout(srl_dout)
`ifdef START_FIFO_SRL_CTRL_OCCUPANCY_EN
        , .occupancy(occupancy), .max_occupancy(max_occupancy)
`endif
    );

    // Behavioural SRL: each write shifts the contents up, and the new word enters at index 0.
    logic [DW-1:0] srl_mem [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (srl_we) begin
            for (int i = (1<<AW)-1; i > 0; i--) srl_mem[i] <= srl_mem[i-1];
            srl_mem[0] <= srl_din;
        end
    end
    assign srl_dout = srl_mem[srl_addr];

    // Reference model
    logic [DW-1:0] q[$];
    int            mx;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock cycle: drive the inputs, check the combinational SRL drive,
    // advance the model, and stop just after the edge.
    task automatic cycle(input logic rst_i, input logic wr_i, input logic rd_i,
                         input logic [DW-1:0] din_i);
        logic exp_push, exp_pop;
        @(negedge clk);
        reset = rst_i; if_write_ce = wr_i; if_write = wr_i;
        if_read_ce = rd_i; if_read = rd_i; if_din = din_i;
        exp_push = wr_i && (q.size() < DEPTH);
        exp_pop  = rd_i && (q.size() != 0);
        #1;
        chk("srl_we", {31'd0, srl_we}, {31'd0, exp_push});
        chk("srl_din", {24'd0, srl_din}, {24'd0, din_i});
        if (rst_i) begin
            q.delete();
            mx = 0;
        end else begin
            if (exp_pop)  void'(q.pop_front());
            if (exp_push) q.push_back(din_i);
            if (q.size() > mx) mx = q.size();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".empty_n"}, {31'd0, if_empty_n}, {31'd0, q.size() != 0});
        chk({tag, ".full_n"},  {31'd0, if_full_n},  {31'd0, q.size() != DEPTH});
        chk({tag, ".addr"}, {30'd0, srl_addr}, (q.size() > 0) ? q.size() - 1 : 0);
        if (q.size() != 0) chk({tag, ".dout"}, {24'd0, if_dout}, {24'd0, q[0]});
`ifdef START_FIFO_SRL_CTRL_OCCUPANCY_EN
        chk({tag, ".occ"}, {29'd0, occupancy}, q.size());
        chk({tag, ".maxocc"}, {29'd0, max_occupancy}, mx);
`endif
    endtask

    // Post-edge expectation: the flags and addr; dout only when chk_dout is set.
    task automatic chk_state(input string tag, input logic e_n, input logic f_n,
                             input logic [AW-1:0] addr, input logic chk_dout,
                             input logic [DW-1:0] dout);
        chk({tag, ".empty_n"}, {31'd0, if_empty_n}, {31'd0, e_n});
        chk({tag, ".full_n"},  {31'd0, if_full_n},  {31'd0, f_n});
        chk({tag, ".addr"},    {30'd0, srl_addr},   {30'd0, addr});
        if (chk_dout) chk({tag, ".dout"}, {24'd0, if_dout}, {24'd0, dout});
    endtask

    typedef struct {
        logic          rst, wr, rd;
        logic [DW-1:0] din;
        logic          e_n, f_n;
        logic [AW-1:0] addr;
        logic          chk_dout;
        logic [DW-1:0] dout;
    } vec_t;

    vec_t tbl [9];

    function automatic vec_t mk(logic rst, logic wr, logic rd, logic [DW-1:0] din,
                                logic e_n, logic f_n, logic [AW-1:0] addr,
                                logic cd, logic [DW-1:0] dout);
        vec_t v;
        v.rst = rst; v.wr = wr; v.rd = rd; v.din = din;
        v.e_n = e_n; v.f_n = f_n; v.addr = addr; v.chk_dout = cd; v.dout = dout;
        return v;
    endfunction

    initial begin
        reset = 1'b0; if_write_ce = 1'b0; if_write = 1'b0;
        if_read_ce = 1'b0; if_read = 1'b0; if_din = '0;
        mx = 0;

        // Fill then drain
        tbl[0] = mk(1, 0, 0, 8'h00, 0, 1, 2'd0, 0, 8'h00);
        tbl[1] = mk(0, 1, 0, 8'h11, 1, 1, 2'd0, 1, 8'h11);
        tbl[2] = mk(0, 1, 0, 8'h22, 1, 1, 2'd1, 1, 8'h11);
        tbl[3] = mk(0, 1, 0, 8'h33, 1, 1, 2'd2, 1, 8'h11);
        tbl[4] = mk(0, 1, 0, 8'h44, 1, 0, 2'd3, 1, 8'h11);
        tbl[5] = mk(0, 0, 1, 8'h00, 1, 1, 2'd2, 1, 8'h22);
        tbl[6] = mk(0, 0, 1, 8'h00, 1, 1, 2'd1, 1, 8'h33);
        tbl[7] = mk(0, 0, 1, 8'h00, 1, 1, 2'd0, 1, 8'h44);
        tbl[8] = mk(0, 0, 1, 8'h00, 0, 1, 2'd0, 0, 8'h00);
        for (int i = 0; i < 9; i++) begin
            cycle(tbl[i].rst, tbl[i].wr, tbl[i].rd, tbl[i].din);
            chk_state($sformatf("tbl%0d", i), tbl[i].e_n, tbl[i].f_n, tbl[i].addr,
                      tbl[i].chk_dout, tbl[i].dout);
        end

        // Simultaneous push and pop with two entries held
        cycle(1, 0, 0, 8'h00);
        cycle(0, 1, 0, 8'hA0);
        cycle(0, 1, 0, 8'hA1);
        chk_state("pp_pre", 1, 1, 2'd1, 1, 8'hA0);
        cycle(0, 1, 1, 8'hA2);
        chk_state("pp", 1, 1, 2'd1, 1, 8'hA1);
        cycle(0, 0, 1, 8'h00);
        chk_state("pp_pop", 1, 1, 2'd0, 1, 8'hA2);

        // A write is blocked while full, even when a pop happens in the same cycle
        cycle(1, 0, 0, 8'h00);
        for (int i = 1; i <= 4; i++) cycle(0, 1, 0, DW'(i));
        chk_state("full", 1, 0, 2'd3, 1, 8'h01);
        cycle(0, 1, 1, 8'h55);
        chk_state("fullblk", 1, 1, 2'd2, 1, 8'h02);
        cycle(0, 0, 1, 8'h00);
        chk_state("fb_pop1", 1, 1, 2'd1, 1, 8'h03);
        cycle(0, 0, 1, 8'h00);
        chk_state("fb_pop2", 1, 1, 2'd0, 1, 8'h04);
        cycle(0, 0, 1, 8'h00);
        chk_state("fb_pop3", 0, 1, 2'd0, 0, 8'h00);

        // A read while empty is ignored
        cycle(0, 0, 1, 8'h00);
        chk_state("emptyrd", 0, 1, 2'd0, 0, 8'h00);

        // Reset in mid-operation, with a push asserted in the same cycle
        for (int i = 0; i < 3; i++) cycle(0, 1, 0, 8'hC0 + DW'(i));
        chk_state("mid_pre", 1, 1, 2'd2, 1, 8'hC0);
        cycle(1, 1, 1, 8'hEE);
        chk_state("midrst", 0, 1, 2'd0, 0, 8'h00);

`ifdef START_FIFO_SRL_CTRL_OCCUPANCY_EN
        // Watermark is sticky after a drain and cleared by reset
        for (int i = 0; i < 3; i++) cycle(0, 1, 0, DW'(i));
        for (int i = 0; i < 3; i++) cycle(0, 0, 1, 8'h00);
        chk("wm_occ", {29'd0, occupancy}, 0);
        chk("wm_max", {29'd0, max_occupancy}, 3);
        cycle(0, 0, 0, 8'h00);
        chk("wm_hold", {29'd0, max_occupancy}, 3);
        cycle(1, 0, 0, 8'h00);
        chk("wm_rst", {29'd0, max_occupancy}, 0);
`endif

        // Random traffic, with the write/read bias alternating to reach both full and empty
        for (int i = 0; i < 600; i++) begin
            logic rst_r, wr_r, rd_r;
            int   bias;
            bias  = ((i / 40) % 2 == 0) ? 6 : 2;
            rst_r = ($urandom_range(0, 79) == 0);
            wr_r  = ($urandom_range(0, 7) < bias);
            rd_r  = ($urandom_range(0, 7) < (8 - bias));
            cycle(rst_r, wr_r, rd_r, DW'($urandom));
            check_model("rnd");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
